// File: rtl/tl_ul_fragmenter_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tl_ul_fragmenter_arbiter
// Two-port round-robin TL-UL arbiter with Put-burst lock, source tagging,
// D-channel routing by tag and per-port in-flight caps.
// Rev    : 1.0
// ============================================================================
module tl_ul_fragmenter_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 6,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in0_a_valid,
  output logic              in0_a_ready,
  input  logic [2:0]        in0_a_opcode,
  input  logic [2:0]        in0_a_param,
  input  logic [2:0]        in0_a_size,
  input  logic [SRC_W-1:0]  in0_a_source,
  input  logic [ADDR_W-1:0] in0_a_address,
  input  logic [3:0]        in0_a_mask,
  input  logic [DATA_W-1:0] in0_a_data,
  input  logic              in1_a_valid,
  output logic              in1_a_ready,
  input  logic [2:0]        in1_a_opcode,
  input  logic [2:0]        in1_a_param,
  input  logic [2:0]        in1_a_size,
  input  logic [SRC_W-1:0]  in1_a_source,
  input  logic [ADDR_W-1:0] in1_a_address,
  input  logic [3:0]        in1_a_mask,
  input  logic [DATA_W-1:0] in1_a_data,
  output logic              in0_d_valid,
  input  logic              in0_d_ready,
  output logic [2:0]        in0_d_opcode,
  output logic [1:0]        in0_d_param,
  output logic [2:0]        in0_d_size,
  output logic [SRC_W-1:0]  in0_d_source,
  output logic [DATA_W-1:0] in0_d_data,
  output logic              in1_d_valid,
  input  logic              in1_d_ready,
  output logic [2:0]        in1_d_opcode,
  output logic [1:0]        in1_d_param,
  output logic [2:0]        in1_d_size,
  output logic [SRC_W-1:0]  in1_d_source,
  output logic [DATA_W-1:0] in1_d_data,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [2:0]        out_a_opcode,
  output logic [2:0]        out_a_param,
  output logic [2:0]        out_a_size,
  output logic [SRC_W:0]    out_a_source,
  output logic [ADDR_W-1:0] out_a_address,
  output logic [3:0]        out_a_mask,
  output logic [DATA_W-1:0] out_a_data,
  input  logic              out_d_valid,
  output logic              out_d_ready,
  input  logic [2:0]        out_d_opcode,
  input  logic [1:0]        out_d_param,
  input  logic [2:0]        out_d_size,
  input  logic [SRC_W:0]    out_d_source,
  input  logic [DATA_W-1:0] out_d_data
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [3:0]      beat_left_q, beat_left_d;
  logic [1:0][3:0] cnt_q, cnt_d;
  logic [1:0][3:0] dcnt_q, dcnt_d;

  logic [1:0]              a_valid, eligible, inc, dec;
  logic [1:0][2:0]         a_opcode, a_param, a_size;
  logic [1:0][SRC_W-1:0]   a_source;
  logic [1:0][ADDR_W-1:0]  a_address;
  logic [1:0][3:0]         a_mask;
  logic [1:0][DATA_W-1:0]  a_data;
  logic                    grant, a_fire, a_last;
  logic                    d_sel, d_fire, d_last;
  logic [3:0]              a_m1, d_m1;

  // Beats minus one for a message of 2^size bytes on a 4-byte bus.
  function automatic logic [3:0] beats_m1(input logic multi, input logic [2:0] size);
    if (multi && size > 3'd2) return 4'((5'd1 << (size - 3'd2)) - 5'd1);
    return 4'd0;
  endfunction

  assign a_valid   = {in1_a_valid, in0_a_valid};
  assign a_opcode  = {in1_a_opcode, in0_a_opcode};
  assign a_param   = {in1_a_param, in0_a_param};
  assign a_size    = {in1_a_size, in0_a_size};
  assign a_source  = {in1_a_source, in0_a_source};
  assign a_address = {in1_a_address, in0_a_address};
  assign a_mask    = {in1_a_mask, in0_a_mask};
  assign a_data    = {in1_a_data, in0_a_data};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      eligible[n] = a_valid[n] && (cnt_q[n] < MAX_CNT || state_q == BURST);
    end
    if (state_q == BURST)  grant = lock_q;
    else if (&eligible)    grant = rr_q;
    else                   grant = eligible[1];
  end

  assign out_a_valid   = eligible[grant] && !reset;
  assign in0_a_ready   = out_a_ready && !grant && eligible[0] && !reset;
  assign in1_a_ready   = out_a_ready &&  grant && eligible[1] && !reset;
  assign out_a_opcode  = a_opcode[grant];
  assign out_a_param   = a_param[grant];
  assign out_a_size    = a_size[grant];
  assign out_a_source  = {grant, a_source[grant]};
  assign out_a_address = a_address[grant];
  assign out_a_mask    = a_mask[grant];
  assign out_a_data    = a_data[grant];

  assign a_fire = out_a_valid && out_a_ready;
  assign a_m1   = beats_m1(out_a_opcode[2:1] == 2'b00, out_a_size);
  assign a_last = (state_q == IDLE) ? (a_m1 == 4'd0) : (beat_left_q == 4'd1);

  // D return path: purely combinational, steered by the tag bit.
  assign d_sel        = out_d_source[SRC_W];
  assign in0_d_valid  = out_d_valid && !d_sel;
  assign in1_d_valid  = out_d_valid &&  d_sel;
  assign out_d_ready  = d_sel ? in1_d_ready : in0_d_ready;
  assign in0_d_opcode = out_d_opcode;
  assign in1_d_opcode = out_d_opcode;
  assign in0_d_param  = out_d_param;
  assign in1_d_param  = out_d_param;
  assign in0_d_size   = out_d_size;
  assign in1_d_size   = out_d_size;
  assign in0_d_source = out_d_source[SRC_W-1:0];
  assign in1_d_source = out_d_source[SRC_W-1:0];
  assign in0_d_data   = out_d_data;
  assign in1_d_data   = out_d_data;

  assign d_fire = out_d_valid && out_d_ready;
  assign d_m1   = beats_m1(out_d_opcode == 3'd1, out_d_size);
  assign d_last = (dcnt_q[d_sel] == d_m1);

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    beat_left_d = beat_left_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    if (a_fire) begin
      if (state_q == IDLE) begin
        if (!a_last) begin
          state_d     = BURST;
          lock_d      = grant;
          beat_left_d = a_m1;
        end
      end else begin
        beat_left_d = beat_left_q - 4'd1;
        if (a_last) state_d = IDLE;
      end
      if (a_last) rr_d = ~grant;
    end
    for (int n = 0; n < 2; n++) begin
      inc[n] = a_fire && a_last && (grant == 1'(n));
      dec[n] = d_fire && d_last && (d_sel == 1'(n));
      case ({inc[n], dec[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + 4'd1;
        2'b01:   cnt_d[n] = cnt_q[n] - 4'd1;
        default: cnt_d[n] = cnt_q[n];
      endcase
      if (d_fire && d_sel == 1'(n)) dcnt_d[n] = d_last ? 4'd0 : dcnt_q[n] + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      beat_left_q <= 4'd0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      beat_left_q <= beat_left_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
    end
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_cnt_chk
      assert property (@(posedge clock) disable iff (reset)
        !(dec[g] && !inc[g] && cnt_q[g] == 4'd0));
      assert property (@(posedge clock) disable iff (reset)
        !(inc[g] && !dec[g] && cnt_q[g] == MAX_CNT));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_fragmenter_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_tl_ul_fragmenter_arbiter
// Directed scenarios plus randomized traffic against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_tl_ul_fragmenter_arbiter;
  localparam int ADDR_W = 12, DATA_W = 32, SRC_W = 6, MAX_OUT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic              in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
  logic [2:0]        in0_a_opcode, in0_a_param, in0_a_size, in1_a_opcode, in1_a_param, in1_a_size;
  logic [SRC_W-1:0]  in0_a_source, in1_a_source;
  logic [ADDR_W-1:0] in0_a_address, in1_a_address;
  logic [3:0]        in0_a_mask, in1_a_mask;
  logic [DATA_W-1:0] in0_a_data, in1_a_data;
  logic              in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;
  logic [2:0]        in0_d_opcode, in0_d_size, in1_d_opcode, in1_d_size;
  logic [1:0]        in0_d_param, in1_d_param;
  logic [SRC_W-1:0]  in0_d_source, in1_d_source;
  logic [DATA_W-1:0] in0_d_data, in1_d_data;
  logic              out_a_valid, out_a_ready;
  logic [2:0]        out_a_opcode, out_a_param, out_a_size;
  logic [SRC_W:0]    out_a_source;
  logic [ADDR_W-1:0] out_a_address;
  logic [3:0]        out_a_mask;
  logic [DATA_W-1:0] out_a_data;
  logic              out_d_valid, out_d_ready;
  logic [2:0]        out_d_opcode, out_d_size;
  logic [1:0]        out_d_param;
  logic [SRC_W:0]    out_d_source;
  logic [DATA_W-1:0] out_d_data;

  always #5 clock = ~clock;

  tl_ul_fragmenter_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
    .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
    .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_param(in0_d_param), .in0_d_size(in0_d_size), .in0_d_source(in0_d_source),
    .in0_d_data(in0_d_data),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_param(in1_d_param), .in1_d_size(in1_d_size), .in1_d_source(in1_d_source),
    .in1_d_data(in1_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_data(out_d_data)
  );

  typedef struct { logic [2:0] op; logic [2:0] size; logic [5:0] src; logic [11:0] addr; } msg_t;
  typedef struct { int port; logic [5:0] src; logic [2:0] op; logic [2:0] size; int beats; } rsp_t;

  int n_total = 0, n_bad = 0;
  msg_t mq0[$], mq1[$];
  msg_t cur[2];
  logic cur_act[2];
  logic [31:0] cur_data[2];
  logic [3:0]  cur_mask[2];
  rsp_t rsp[$];
  int d_beat = 0;
  logic [31:0] d_data;
  int outst[2];
  int lock_port = -1, left = 0, prefer = 0;
  bit rand_mode = 0, a_rdy = 1, d_gate = 1;
  bit dr[2];
  int d_allow = 1 << 30;
  int dut_beats[2], dut_d[2];
  int fire_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int beats_of(input bit multi, input logic [2:0] size);
    if (multi && size > 2) return 1 << (int'(size) - 2);
    return 1;
  endfunction

  function automatic msg_t mk(input logic [2:0] op, input logic [2:0] size, input logic [5:0] src);
    msg_t m;
    m.op = op; m.size = size; m.src = src; m.addr = 12'($urandom);
    return m;
  endfunction

  function automatic msg_t rnd_msg();
    logic [2:0] op;
    case ($urandom_range(0, 2))
      0:       op = 3'd0;
      1:       op = 3'd1;
      default: op = 3'd4;
    endcase
    return mk(op, 3'($urandom_range(0, 6)), 6'($urandom));
  endfunction

  task automatic step();
    int w, sel, nb;
    bit e0, e1, dv, last;
    rsp_t r;
    if (rand_mode) begin
      a_rdy = ($urandom_range(0, 3) != 0);
      d_gate = ($urandom_range(0, 3) != 0);
      dr[0] = ($urandom_range(0, 3) != 0);
      dr[1] = ($urandom_range(0, 3) != 0);
      if (!cur_act[0] && mq0.size() == 0 && $urandom_range(0, 3) == 0) mq0.push_back(rnd_msg());
      if (!cur_act[1] && mq1.size() == 0 && $urandom_range(0, 3) == 0) mq1.push_back(rnd_msg());
    end
    if (!cur_act[0] && mq0.size() > 0) begin
      cur[0] = mq0.pop_front(); cur_act[0] = 1; cur_data[0] = $urandom; cur_mask[0] = 4'($urandom);
    end
    if (!cur_act[1] && mq1.size() > 0) begin
      cur[1] = mq1.pop_front(); cur_act[1] = 1; cur_data[1] = $urandom; cur_mask[1] = 4'($urandom);
    end
    @(negedge clock);
    in0_a_valid = cur_act[0]; in0_a_opcode = cur[0].op; in0_a_param = 3'd0; in0_a_size = cur[0].size;
    in0_a_source = cur[0].src; in0_a_address = cur[0].addr; in0_a_mask = cur_mask[0]; in0_a_data = cur_data[0];
    in1_a_valid = cur_act[1]; in1_a_opcode = cur[1].op; in1_a_param = 3'd0; in1_a_size = cur[1].size;
    in1_a_source = cur[1].src; in1_a_address = cur[1].addr; in1_a_mask = cur_mask[1]; in1_a_data = cur_data[1];
    out_a_ready = a_rdy; in0_d_ready = dr[0]; in1_d_ready = dr[1]; out_d_param = 2'd0;
    if (rsp.size() > 0) begin
      out_d_valid = d_gate && (d_allow > 0);
      out_d_source = {1'(rsp[0].port), rsp[0].src};
      out_d_opcode = rsp[0].op; out_d_size = rsp[0].size; out_d_data = d_data;
    end else begin
      out_d_valid = 0; out_d_source = '0; out_d_opcode = 0; out_d_size = 0; out_d_data = 0;
    end
    #1;
    if (in0_a_valid && in0_a_ready) begin dut_beats[0]++; fire_log.push_back(0); end
    if (in1_a_valid && in1_a_ready) begin dut_beats[1]++; fire_log.push_back(1); end
    if (in0_d_valid && in0_d_ready) dut_d[0]++;
    if (in1_d_valid && in1_d_ready) dut_d[1]++;

    // Transaction-level arbitration model
    w = -1;
    if (lock_port >= 0) begin
      if (cur_act[lock_port]) w = lock_port;
    end else begin
      e0 = cur_act[0] && outst[0] < MAX_OUT;
      e1 = cur_act[1] && outst[1] < MAX_OUT;
      if (e0 && e1) w = prefer;
      else if (e0)  w = 0;
      else if (e1)  w = 1;
    end
    check_eq("a_valid", out_a_valid, w >= 0);
    check_eq("a_ready0", in0_a_ready, w == 0 && a_rdy);
    check_eq("a_ready1", in1_a_ready, w == 1 && a_rdy);
    if (w >= 0) begin
      check_eq("a_source", out_a_source, {w[0], cur[w].src});
      check_eq("a_data", out_a_data, cur_data[w]);
      check_eq("a_mask", out_a_mask, cur_mask[w]);
      check_eq("a_addr", out_a_address, cur[w].addr);
      check_eq("a_opsize", {out_a_opcode, out_a_size}, {cur[w].op, cur[w].size});
    end
    if (w >= 0 && a_rdy) begin
      nb = beats_of(cur[w].op != 3'd4, cur[w].size);
      last = 0;
      if (lock_port < 0) begin
        if (nb > 1) begin lock_port = w; left = nb - 1; end
        else last = 1;
      end else begin
        left--;
        if (left == 0) begin lock_port = -1; last = 1; end
      end
      cur_data[w] = $urandom; cur_mask[w] = 4'($urandom);
      if (last) begin
        cur_act[w] = 0; outst[w]++; prefer = 1 - w;
        r.port = w; r.src = cur[w].src; r.size = cur[w].size;
        r.op = (cur[w].op == 3'd4) ? 3'd1 : 3'd0;
        r.beats = beats_of(r.op == 3'd1, r.size);
        rsp.push_back(r);
      end
    end

    sel = int'(out_d_source[SRC_W]);
    dv = out_d_valid;
    check_eq("d_valid0", in0_d_valid, dv && sel == 0);
    check_eq("d_valid1", in1_d_valid, dv && sel == 1);
    check_eq("d_ready", out_d_ready, dr[sel]);
    if (dv) begin
      if (sel == 0) begin
        check_eq("d_src0", in0_d_source, rsp[0].src);
        check_eq("d_data0", in0_d_data, d_data);
        check_eq("d_opsize0", {in0_d_opcode, in0_d_size}, {rsp[0].op, rsp[0].size});
      end else begin
        check_eq("d_src1", in1_d_source, rsp[0].src);
        check_eq("d_data1", in1_d_data, d_data);
        check_eq("d_opsize1", {in1_d_opcode, in1_d_size}, {rsp[0].op, rsp[0].size});
      end
      if (dr[sel]) begin
        d_beat++; d_data = $urandom;
        if (d_beat == rsp[0].beats) begin
          outst[rsp[0].port]--; void'(rsp.pop_front()); d_beat = 0; d_allow--;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    in0_a_valid = 1; in1_a_valid = 1; out_a_ready = 1;
    out_d_valid = 1; out_d_source = 7'h45; in0_d_ready = 1; in1_d_ready = 0;
    #1;
    check_eq("rst_a_valid", out_a_valid, 0);
    check_eq("rst_ready0", in0_a_ready, 0);
    check_eq("rst_ready1", in1_a_ready, 0);
    check_eq("rst_d_follow", {in1_d_valid, in0_d_valid, out_d_ready}, 3'b100);
    outst = '{0, 0}; lock_port = -1; left = 0; prefer = 0;
    rsp.delete(); d_beat = 0; cur_act = '{0, 0}; mq0.delete(); mq1.delete();
    @(negedge clock);
    in0_a_valid = 0; in1_a_valid = 0; out_d_valid = 0;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((cur_act[0] || cur_act[1] || mq0.size() > 0 || mq1.size() > 0 || rsp.size() > 0) && k < 3000) begin
      step(); k++;
    end
    if (k >= 3000) check_eq("drain_timeout", k, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, based;
    dr = '{1, 1}; cur_act = '{0, 0}; outst = '{0, 0}; dut_beats = '{0, 0}; dut_d = '{0, 0};
    d_data = $urandom;
    in0_a_valid = 0; in1_a_valid = 0; out_a_ready = 0; out_d_valid = 0; in0_d_ready = 0; in1_d_ready = 0;
    do_reset();

    // Put burst holds the grant; pending Get on the other port follows.
    fire_log.delete();
    mq0.push_back(mk(3'd0, 3'd4, 6'd3));
    mq1.push_back(mk(3'd4, 3'd2, 6'd7));
    repeat (8) step();
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("burst_seq%0d", i), (i < fire_log.size()) ? fire_log[i] : -1, (i < 4) ? 0 : 1);
    drain();

    // Back-to-back Gets from both ports alternate.
    fire_log.delete();
    for (int i = 0; i < 4; i++) begin
      mq0.push_back(mk(3'd4, 3'd2, 6'(i)));
      mq1.push_back(mk(3'd4, 3'd2, 6'(8 + i)));
    end
    repeat (10) step();
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("rr_seq%0d", i), (i < fire_log.size()) ? fire_log[i] : -1, i % 2);
    drain();

    // In-flight cap on port 1.
    d_allow = 0; base = dut_beats[1];
    for (int i = 0; i < 5; i++) mq1.push_back(mk(3'd4, 3'd2, 6'(i)));
    repeat (12) step();
    check_eq("cap_held", dut_beats[1] - base, 4);
    d_allow = 1;
    repeat (6) step();
    check_eq("cap_release", dut_beats[1] - base, 5);
    d_allow = 1 << 30;
    drain();

    // Multi-beat AccessAckData routed to port 0 only.
    d_allow = 0;
    mq0.push_back(mk(3'd4, 3'd4, 6'h05));
    repeat (3) step();
    based = dut_d[1]; base = dut_d[0];
    d_allow = 1 << 30;
    repeat (8) step();
    check_eq("d_burst_beats0", dut_d[0] - base, 4);
    check_eq("d_burst_beats1", dut_d[1] - based, 0);
    drain();

    // Stall out_a_ready for 3 cycles while beat 2 is presented.
    base = dut_beats[0];
    mq0.push_back(mk(3'd0, 3'd4, 6'd9));
    for (int k = 0; k < 20 && dut_beats[0] - base < 1; k++) step();
    a_rdy = 0;
    repeat (3) step();
    check_eq("stall_held", dut_beats[0] - base, 1);
    a_rdy = 1;
    for (int k = 0; k < 20 && dut_beats[0] - base < 4; k++) step();
    check_eq("stall_done", dut_beats[0] - base, 4);
    drain();

    // Reset in the middle of an 8-beat burst.
    base = dut_beats[0];
    mq0.push_back(mk(3'd0, 3'd5, 6'd1));
    for (int k = 0; k < 20 && dut_beats[0] - base < 2; k++) step();
    check_eq("pre_rst_beats", dut_beats[0] - base, 2);
    do_reset();
    #1;
    check_eq("post_rst_valid", out_a_valid, 0);
    fire_log.delete();
    mq1.push_back(mk(3'd4, 3'd2, 6'd2));
    repeat (3) step();
    check_eq("post_rst_grant", (fire_log.size() == 1) ? fire_log[0] : -1, 1);
    drain();

    // Randomized traffic
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0; a_rdy = 1; d_gate = 1; dr = '{1, 1};
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
